// File: rtl/rep3_encoder_tx_if.sv
// rtl/rep3_encoder_tx_if.sv - word-in / serial-beat-out bundle for the repetition-code transmitter
interface rep3_encoder_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              tx_bit;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_sob;
  logic              tx_last;
  logic              busy;

  modport master (
    output in_data, in_valid, tx_ready,
    input  in_ready, tx_bit, tx_valid, tx_sob, tx_last, busy
  );

  modport slave (
    input  in_data, in_valid, tx_ready,
    output in_ready, tx_bit, tx_valid, tx_sob, tx_last, busy
  );
endinterface

// File: rtl/rep3_encoder_tx.sv
// rtl/rep3_encoder_tx.sv - repetition-code transmitter, MSB-first, each bit sent REP times
module rep3_encoder_tx #(
  parameter int DATA_W = 8,
  parameter int REP    = 3
) (
  input  logic              clk,
  input  logic              rst,
  rep3_encoder_tx_if.slave  bus
);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int RW = (REP > 1) ? $clog2(REP) : 1;
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W - 1);
  localparam logic [RW-1:0] REP_MAX = RW'(REP - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [RW-1:0]     rep_cnt_q, rep_cnt_d;
  logic              tx_bit_q, tx_bit_d;
  logic              tx_valid_q, tx_valid_d;
  logic              tx_sob_q, tx_sob_d;
  logic              tx_last_q, tx_last_d;

  logic              beat;
  logic              in_ready;
  logic              accept;
  logic [DATA_W-1:0] shift_nx;
  logic [BW-1:0]     bit_inc;
  logic [RW-1:0]     rep_inc;

  assign beat     = tx_valid_q && bus.tx_ready;
  // Final beat being consumed frees the slot on the same edge: zero-bubble back-to-back words.
  assign in_ready = !rst && ((state_q == S_IDLE) || (beat && tx_last_q));
  assign accept   = bus.in_valid && in_ready;
  assign shift_nx = shift_q << 1;
  assign bit_inc  = bit_cnt_q + BW'(1);
  assign rep_inc  = rep_cnt_q + RW'(1);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_valid_d = tx_valid_q;
    tx_sob_d   = tx_sob_q;
    tx_last_d  = tx_last_q;
    if (accept) begin
      state_d    = S_SEND;
      shift_d    = bus.in_data;
      bit_cnt_d  = '0;
      rep_cnt_d  = '0;
      tx_bit_d   = bus.in_data[DATA_W-1];
      tx_valid_d = 1'b1;
      tx_sob_d   = 1'b1;
      tx_last_d  = (BIT_MAX == '0) && (REP_MAX == '0);
    end else if (beat) begin
      if (tx_last_q) begin
        state_d    = S_IDLE;
        bit_cnt_d  = '0;
        rep_cnt_d  = '0;
        tx_valid_d = 1'b0;
        tx_sob_d   = 1'b0;
        tx_last_d  = 1'b0;
      end else if (rep_cnt_q == REP_MAX) begin
        shift_d   = shift_nx;
        bit_cnt_d = bit_inc;
        rep_cnt_d = '0;
        tx_bit_d  = shift_nx[DATA_W-1];
        tx_sob_d  = 1'b1;
        tx_last_d = (bit_inc == BIT_MAX) && (REP_MAX == '0);
      end else begin
        rep_cnt_d = rep_inc;
        tx_sob_d  = 1'b0;
        tx_last_d = (bit_cnt_q == BIT_MAX) && (rep_inc == REP_MAX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      rep_cnt_q  <= '0;
      tx_bit_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_sob_q   <= 1'b0;
      tx_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_valid_q <= tx_valid_d;
      tx_sob_q   <= tx_sob_d;
      tx_last_q  <= tx_last_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.tx_bit   = tx_bit_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_sob   = tx_sob_q;
  assign bus.tx_last  = tx_last_q;
  assign bus.busy     = (state_q == S_SEND);
endmodule

// File: tb/tb_rep3_encoder_tx.sv
// tb/tb_rep3_encoder_tx.sv - bench for rep3_encoder_tx at (8,3), (1,1) and (16,5)
module tb_rep3_encoder_tx;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rep3_encoder_tx_if #(.DATA_W(8))  b0 ();
  rep3_encoder_tx_if #(.DATA_W(1))  b1 ();
  rep3_encoder_tx_if #(.DATA_W(16)) b2 ();

  rep3_encoder_tx #(.DATA_W(8),  .REP(3)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  rep3_encoder_tx #(.DATA_W(1),  .REP(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  rep3_encoder_tx #(.DATA_W(16), .REP(5)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  int checks = 0;
  int errors = 0;
  logic [15:0] words_q[$];
  logic [15:0] acc_q[$];
  logic [2:0]  got_q[$];
  logic [2:0]  exp_q[$];
  int ir_send, gaps, frozen_viol;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {in_ready, tx_valid, tx_bit, tx_sob, tx_last, busy}
  function automatic logic [5:0] outs(input int inst);
    case (inst)
      0:       return {b0.in_ready, b0.tx_valid, b0.tx_bit, b0.tx_sob, b0.tx_last, b0.busy};
      1:       return {b1.in_ready, b1.tx_valid, b1.tx_bit, b1.tx_sob, b1.tx_last, b1.busy};
      default: return {b2.in_ready, b2.tx_valid, b2.tx_bit, b2.tx_sob, b2.tx_last, b2.busy};
    endcase
  endfunction

  task automatic drv(input int inst, input logic v, input logic [15:0] d, input logic r);
    case (inst)
      0: begin b0.in_valid = v; b0.in_data = d[7:0]; b0.tx_ready = r; end
      1: begin b1.in_valid = v; b1.in_data = d[0:0]; b1.tx_ready = r; end
      default: begin b2.in_valid = v; b2.in_data = d; b2.tx_ready = r; end
    endcase
  endtask

  // mode 0: always ready, 1: stall beats 2,3,23 for 4 cycles each, 2: random ready
  task automatic run(input int inst, input int dw, input int rep, input int mode, input bit toggle);
    int n, idx, total, stall_left;
    logic [15:0] d, mask;
    logic v, r, acc;
    bit prev_stall;
    bit dn [64];
    logic [5:0] o, po;
    n = words_q.size();
    idx = 0;
    total = n * dw * rep;
    mask = (dw == 16) ? 16'hFFFF : 16'((32'd1 << dw) - 1);
    d = toggle ? 16'($urandom) : words_q[0];
    v = 1'b1;
    r = (mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
    stall_left = 0;
    prev_stall = 1'b0;
    po = '0;
    foreach (dn[i]) dn[i] = 1'b0;
    acc_q.delete(); got_q.delete();
    ir_send = 0; gaps = 0; frozen_viol = 0;
    @(posedge clk); #1;
    drv(inst, v, d, r);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      o = outs(inst);
      if (prev_stall && (o[4:1] !== po[4:1])) frozen_viol++;
      if (!o[4] && acc_q.size() > 0 && got_q.size() < acc_q.size() * dw * rep) gaps++;
      if (o[4] && r) got_q.push_back(o[3:1]);
      if (o[5] && o[4]) ir_send++;
      acc = v && o[5];
      if (acc) acc_q.push_back(d & mask);
      prev_stall = o[4] && !r;
      po = o;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx >= n) v = 1'b0;
        else if (!toggle) d = words_q[idx];
      end
      if (toggle) d = 16'($urandom);
      if (mode == 0) r = 1'b1;
      else if (mode == 2) r = ($urandom_range(0, 2) != 0);
      else if (stall_left > 0) begin
        r = 1'b0;
        stall_left--;
      end else if ((got_q.size() + 1 == 2 || got_q.size() + 1 == 3 || got_q.size() + 1 == 23)
                   && !dn[got_q.size() + 1]) begin
        dn[got_q.size() + 1] = 1'b1;
        r = 1'b0;
        stall_left = 3;
      end else r = 1'b1;
      drv(inst, v, d, r);
      if (got_q.size() >= total) break;
    end
  endtask

  // Reference: every accepted word expands to dw groups of rep copies, MSB first.
  task automatic cmp(input string tag, input int dw, input int rep, input int nwords);
    int mism, dmis, ones, k;
    logic [15:0] dec;
    exp_q.delete();
    foreach (acc_q[w])
      for (int i = dw - 1; i >= 0; i--)
        for (int j = 0; j < rep; j++)
          exp_q.push_back({acc_q[w][i], j == 0, (i == 0) && (j == rep - 1)});
    chk({tag, "_words"}, acc_q.size(), nwords);
    chk({tag, "_beats"}, got_q.size(), nwords * dw * rep);
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    chk({tag, "_stream"}, mism, 0);
    dmis = 0;
    foreach (acc_q[w]) begin
      dec = '0;
      for (int b = 0; b < dw; b++) begin
        ones = 0;
        for (int j = 0; j < rep; j++) begin
          k = (w * dw + b) * rep + j;
          if (k < got_q.size()) ones += int'(got_q[k][2]);
        end
        dec = {dec[14:0], ones * 2 > rep};
      end
      if (dec !== acc_q[w]) dmis++;
    end
    chk({tag, "_majority"}, dmis, 0);
    chk({tag, "_ready_in_send"}, ir_send, nwords);
    chk({tag, "_gaps"}, gaps, 0);
    chk({tag, "_frozen"}, frozen_viol, 0);
  endtask

  task automatic chk_idle(input string tag, input int inst);
    logic [5:0] o;
    @(negedge clk);
    o = outs(inst);
    chk({tag, "_idle_valid"}, o[4], 1'b0);
    chk({tag, "_idle_busy"}, o[0], 1'b0);
    chk({tag, "_idle_ready"}, o[5], 1'b1);
  endtask

  logic [23:0] pk_bit, pk_sob, pk_last;
  logic [5:0]  o;

  initial begin
    rst = 1'b1;
    drv(0, 1'b1, 16'hA5, 1'b1);
    drv(1, 1'b1, 16'h1, 1'b1);
    drv(2, 1'b1, 16'h1234, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs_u0", outs(0), 6'b0);
    chk("rst_outs_u1", outs(1), 6'b0);
    chk("rst_outs_u2", outs(2), 6'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    drv(0, 1'b0, 16'h0, 1'b0);
    drv(1, 1'b0, 16'h0, 1'b0);
    drv(2, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    chk("idle_after_rst", outs(0), 6'b100000);

    // single word, exact beat pattern
    words_q = {16'hA5};
    run(0, 8, 3, 0, 1'b0);
    cmp("t1", 8, 3, 1);
    pk_bit = '0; pk_sob = '0; pk_last = '0;
    for (int i = 0; i < got_q.size() && i < 24; i++) begin
      pk_bit  = {pk_bit[22:0],  got_q[i][2]};
      pk_sob  = {pk_sob[22:0],  got_q[i][1]};
      pk_last = {pk_last[22:0], got_q[i][0]};
    end
    chk("t1_pattern", pk_bit, 24'hE381C7);
    chk("t1_sob", pk_sob, 24'h924924);
    chk("t1_last", pk_last, 24'h000001);
    chk_idle("t1", 0);

    // back-to-back with in_valid held
    words_q = {16'hFF, 16'h00};
    run(0, 8, 3, 0, 1'b0);
    cmp("t2", 8, 3, 2);
    chk("t2_acc0", acc_q.size() > 0 ? acc_q[0] : 16'hDEAD, 16'hFF);
    chk_idle("t2", 0);

    // downstream stalls
    words_q = {16'h81};
    run(0, 8, 3, 1, 1'b0);
    cmp("t3", 8, 3, 1);
    chk_idle("t3", 0);

    // reset during beat 10 of 0x3C
    @(posedge clk); #1;
    drv(0, 1'b1, 16'h3C, 1'b1);
    @(negedge clk);
    chk("t4_accept_ready", outs(0) >> 5, 1);
    @(posedge clk); #1;
    drv(0, 1'b0, 16'h0, 1'b1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    o = outs(0);
    chk("t4_beat10", o[4:2], 3'b111);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_rst_outs", outs(0), 6'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_idle("t4", 0);
    words_q = {16'h01};
    run(0, 8, 3, 0, 1'b0);
    cmp("t4b", 8, 3, 1);
    chk_idle("t4b", 0);

    // in_data toggles every cycle, random backpressure
    words_q = {16'h0, 16'h0, 16'h0};
    run(0, 8, 3, 2, 1'b1);
    cmp("t5", 8, 3, 3);
    chk_idle("t5", 0);

    // random words, random backpressure
    words_q.delete();
    for (int i = 0; i < 4; i++) words_q.push_back(16'($urandom_range(0, 255)));
    run(0, 8, 3, 2, 1'b0);
    cmp("rnd8x3", 8, 3, 4);
    chk_idle("rnd8x3", 0);

    words_q.delete();
    for (int i = 0; i < 6; i++) words_q.push_back(16'($urandom_range(0, 1)));
    run(1, 1, 1, 2, 1'b0);
    cmp("sw1x1", 1, 1, 6);
    chk_idle("sw1x1", 1);

    words_q.delete();
    for (int i = 0; i < 3; i++) words_q.push_back(16'($urandom));
    run(2, 16, 5, 2, 1'b0);
    cmp("sw16x5", 16, 5, 3);
    chk_idle("sw16x5", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
